// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle.
// Groups everything instr_fetch exchanges with its neighbours. clk and reset
// are not part of this bundle.
//   address     : fetch address from the program counter
//   imem_addr   : instruction memory read address
//   imem_rdata  : memory read data, valid one cycle after imem_addr
//   zero_flag   : ALU zero flag, the branch condition
//   jump/branch : one-cycle redirect pulses to the program counter
//   jump_adr/branch_adr : redirect targets
//   instr/instr_pc/instr_valid : registered instruction handed to decode
//   halted      : fetch has stopped on a HALT
//   retired     : running count of valid instructions delivered
// modport slave is the fetch block; modport master is its surroundings.
interface instr_fetch_if;
  logic [7:0]  address;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        zero_flag;
  logic        jump;
  logic        branch;
  logic [7:0]  jump_adr;
  logic [7:0]  branch_adr;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] retired;

  modport slave (
    input  address, imem_rdata, zero_flag,
    output imem_addr, jump, branch, jump_adr, branch_adr,
    output instr, instr_pc, instr_valid, halted, retired
  );

  modport master (
    output address, imem_rdata, zero_flag,
    input  imem_addr, jump, branch, jump_adr, branch_adr,
    input  instr, instr_pc, instr_valid, halted, retired
  );
endinterface

// File: rtl/instr_fetch.sv
// Two-stage instruction fetch with jump/branch redirect and halt.
// A fetch register (f_pc/f_v) tracks the address whose synchronous memory
// read is currently on imem_rdata. An output register then presents that
// word to decode. Jumps, taken branches and HALT are decoded straight off
// imem_rdata.
// Ports:
//   clk   : clock, rising-edge
//   reset : asynchronous, active-low
//   bus   : instr_fetch_if.slave (see rtl/instr_fetch_if.sv)
//
// state  | meaning
// RUN    | normal fetch; captures are valid unless a redirect/halt is taken
// SQUASH | discarding the wrong-path capture after a redirect
// HALTED | stopped on HALT; only reset leaves this state
module instr_fetch #(
  parameter logic [3:0] JMP_OP  = 4'hE,
  parameter logic [3:0] BEQ_OP  = 4'hF,
  parameter logic [3:0] HALT_OP = 4'hD
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.slave  bus
);

  typedef enum logic [1:0] {RUN, SQUASH, HALTED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sq_cnt_q, sq_cnt_d;
  logic [7:0]  f_pc_q, f_pc_d;
  logic        f_v_q, f_v_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        jump_q, jump_d;
  logic        branch_q, branch_d;
  logic [7:0]  jump_adr_q, jump_adr_d;
  logic [7:0]  branch_adr_q, branch_adr_d;
  logic        halted_q, halted_d;
  logic [15:0] retired_q, retired_d;

  logic [3:0]  opcode;
  logic [7:0]  target;
  logic        dec_en;
  logic        take_jmp;
  logic        take_beq;
  logic        take_halt;
  logic        redirect;

  assign bus.imem_addr = bus.address;

  assign opcode    = bus.imem_rdata[15:12];
  assign target    = bus.imem_rdata[7:0];
  assign dec_en    = f_v_q && (state_q == RUN);
  assign take_jmp  = dec_en && (opcode == JMP_OP);
  assign take_beq  = dec_en && (opcode == BEQ_OP) && bus.zero_flag;
  assign take_halt = dec_en && (opcode == HALT_OP);
  assign redirect  = take_jmp || take_beq;

  always_comb begin
    state_d       = state_q;
    sq_cnt_d      = sq_cnt_q;
    f_pc_d        = bus.address;
    // The capture at a redirect or halt edge is already wrong-path.
    f_v_d         = (state_q == RUN) && !redirect && !take_halt;
    instr_d       = bus.imem_rdata;
    instr_pc_d    = f_pc_q;
    instr_valid_d = dec_en;
    jump_d        = take_jmp;
    branch_d      = take_beq;
    jump_adr_d    = take_jmp ? target : jump_adr_q;
    branch_adr_d  = take_beq ? target : branch_adr_q;
    retired_d     = retired_q + {15'd0, instr_valid_d};

    case (state_q)
      RUN: begin
        if (redirect) begin
          state_d  = SQUASH;
          sq_cnt_d = 2'd2;
        end else if (take_halt) begin
          state_d = HALTED;
        end
      end
      SQUASH: begin
        // The redirect edge's capture was the first of the two squashed ones.
        // Dropping to 1 here marks the second, and the next capture is the
        // redirect target, so fetch resumes.
        sq_cnt_d = sq_cnt_q - 2'd1;
        if (sq_cnt_d <= 2'd1) begin
          state_d  = RUN;
          sq_cnt_d = 2'd0;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d  = RUN;
        sq_cnt_d = 2'd0;
      end
    endcase

    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      sq_cnt_q      <= 2'd0;
      f_pc_q        <= 8'd0;
      f_v_q         <= 1'b0;
      instr_q       <= 16'd0;
      instr_pc_q    <= 8'd0;
      instr_valid_q <= 1'b0;
      jump_q        <= 1'b0;
      branch_q      <= 1'b0;
      jump_adr_q    <= 8'd0;
      branch_adr_q  <= 8'd0;
      halted_q      <= 1'b0;
      retired_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      sq_cnt_q      <= sq_cnt_d;
      f_pc_q        <= f_pc_d;
      f_v_q         <= f_v_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      jump_q        <= jump_d;
      branch_q      <= branch_d;
      jump_adr_q    <= jump_adr_d;
      branch_adr_q  <= branch_adr_d;
      halted_q      <= halted_d;
      retired_q     <= retired_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.jump        = jump_q;
  assign bus.branch      = branch_q;
  assign bus.jump_adr    = jump_adr_q;
  assign bus.branch_adr  = branch_adr_q;
  assign bus.halted      = halted_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: program counter and synchronous memory models,
// with a per-cycle scoreboard of expected outputs.
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc = 8'd0;
  logic [7:0] pc_init = 8'd0;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.address = pc;

  always @(posedge clk or negedge reset) begin
    if (!reset)          pc <= pc_init;
    else if (bus.jump)   pc <= bus.jump_adr;
    else if (bus.branch) pc <= bus.branch_adr;
    else                 pc <= pc + 8'd1;
  end

  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit         v;
    logic [7:0] pc;
    logic [15:0] ins;
    bit         j;
    bit         b;
    logic [7:0] adr;
    bit         h;
    bit         hc;
  } exp_t;

  exp_t sb [$];

  function automatic void push(bit v, logic [7:0] p, logic [15:0] ins,
                               bit j, bit b, logic [7:0] adr, bit h, bit hc);
    exp_t e;
    e.v = v; e.pc = p; e.ins = ins; e.j = j; e.b = b; e.adr = adr; e.h = h; e.hc = hc;
    sb.push_back(e);
  endfunction

  function automatic void push_bubble();
    push(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
  endfunction

  function automatic void push_plain(logic [7:0] p, logic [15:0] ins);
    push(1'b1, p, ins, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
  endfunction

  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("instr_valid", bus.instr_valid, e.v);
        check("jump", bus.jump, e.j);
        check("branch", bus.branch, e.b);
        if (e.v) begin
          check("instr_pc", bus.instr_pc, e.pc);
          check("instr", bus.instr, e.ins);
        end
        if (e.j) check("jump_adr", bus.jump_adr, e.adr);
        if (e.b) check("branch_adr", bus.branch_adr, e.adr);
        if (e.hc) check("halted", bus.halted, e.h);
      end
    end
  endtask

  // Asserts reset immediately, checks the cleared outputs, releases on a
  // falling edge so the next rising edge is the first capture.
  task automatic do_reset(input logic [7:0] start);
    pc_init = start;
    reset = 1'b0;
    #1;
    check("rst_instr", bus.instr, 16'd0);
    check("rst_instr_pc", bus.instr_pc, 8'd0);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_jump", bus.jump, 1'b0);
    check("rst_branch", bus.branch, 1'b0);
    check("rst_jump_adr", bus.jump_adr, 8'd0);
    check("rst_branch_adr", bus.branch_adr, 8'd0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_retired", bus.retired, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h06] = 16'hE001;
    mem[8'h10] = 16'hF080;
    mem[8'h20] = 16'hF080;
    mem[8'h31] = 16'hD000;
    mem[8'h32] = 16'hE040;
    mem[8'h40] = 16'hE050;
    mem[8'h70] = 16'hE0FF;
    bus.zero_flag = 1'b0;

    // Sequential fetch then jump back to 1.
    @(negedge clk);
    do_reset(8'h00);
    push_bubble();
    for (int i = 0; i < 6; i++) push_plain(i[7:0], 16'h0000);
    push(1'b1, 8'h06, 16'hE001, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    push_bubble();
    push_bubble();
    push_plain(8'h01, 16'h0000);
    push_plain(8'h02, 16'h0000);
    run(7);
    check("retired_seq", bus.retired, 16'd6);
    run(2);
    check("jump_adr_hold", bus.jump_adr, 8'h01);
    run(3);
    check("retired_jmp", bus.retired, 16'd9);
    check("sb_left", sb.size(), 0);

    // Taken branch.
    bus.zero_flag = 1'b1;
    do_reset(8'h10);
    push_bubble();
    push(1'b1, 8'h10, 16'hF080, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    push_bubble();
    push_bubble();
    push_plain(8'h80, 16'h0000);
    run(5);
    check("branch_adr_hold", bus.branch_adr, 8'h80);

    // Branch not taken.
    bus.zero_flag = 1'b0;
    do_reset(8'h20);
    push_bubble();
    push_plain(8'h20, 16'hF080);
    push_plain(8'h21, 16'h0000);
    push_plain(8'h22, 16'h0000);
    run(4);

    // Halt, with a jump opcode right behind it that must be ignored.
    do_reset(8'h30);
    push_bubble();
    push_plain(8'h30, 16'h0000);
    push(1'b1, 8'h31, 16'hD000, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) push(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    run(13);
    check("retired_halt", bus.retired, 16'd2);

    // Reset while squashing.
    do_reset(8'h40);
    push_bubble();
    push(1'b1, 8'h40, 16'hE050, 1'b1, 1'b0, 8'h50, 1'b0, 1'b1);
    run(2);
    do_reset(8'h60);
    push_bubble();
    push_plain(8'h60, 16'h0000);
    run(2);
    check("retired_after_rst", bus.retired, 16'd1);

    // Jump to FF, fetch wraps to 00.
    do_reset(8'h70);
    push_bubble();
    push(1'b1, 8'h70, 16'hE0FF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    push_bubble();
    push_bubble();
    push_plain(8'hFF, 16'h0000);
    push_plain(8'h00, 16'h0000);
    run(6);
    check("sb_left_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
